// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB scheduler: register map, status bits,
// operation and bus-phase encodings.
package uart_apb_pkg;

  localparam logic [7:0] REG_TXB  = 8'h00;
  localparam logic [7:0] REG_RXB  = 8'h01;
  localparam logic [7:0] REG_UBRR = 8'h02;
  localparam logic [7:0] REG_CR0  = 8'h03;
  localparam logic [7:0] REG_CR1  = 8'h04;
  localparam logic [7:0] REG_STAT = 8'h05;

  localparam int RXC  = 0;
  localparam int TXC  = 1;
  localparam int UDRE = 2;
  localparam int FE   = 3;
  localparam int DOR  = 4;

  typedef enum logic [2:0] {
    OP_CFG_UBRR,
    OP_CFG_CR1,
    OP_CFG_CR0,
    OP_POLL,
    OP_RXRD,
    OP_TXWR
  } op_e;

  typedef enum logic [1:0] {
    ST_SETUP,
    ST_ACCESS,
    ST_GAP
  } state_e;

  function automatic logic [7:0] op_reg(input op_e op);
    case (op)
      OP_CFG_UBRR: op_reg = REG_UBRR;
      OP_CFG_CR1:  op_reg = REG_CR1;
      OP_CFG_CR0:  op_reg = REG_CR0;
      OP_POLL:     op_reg = REG_STAT;
      OP_RXRD:     op_reg = REG_RXB;
      default:     op_reg = REG_TXB;
    endcase
  endfunction

  function automatic logic op_is_write(input op_e op);
    op_is_write = (op != OP_POLL) && (op != OP_RXRD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward, wrapping
// to index 0, and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [LW-1:0]   gnt_idx
);

  logic          found;
  logic [LW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_apb_sched.sv
// APB master that configures the UART register block, polls its status,
// drains received bytes and round-robin schedules client bytes for transmit.
module uart_apb_sched
  import uart_apb_pkg::*;
#(
  parameter int         NREQ     = 4,
  parameter logic [7:0] CFG_UBRR = 8'h67,
  parameter logic [7:0] CFG_CR1  = 8'h03,
  parameter logic [7:0] CFG_CR0  = 8'h03
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  output logic              cfg_done,
  output logic [7:0]        fe_count,
  output logic              overrun,
  output logic              pSel,
  output logic              pEnable,
  output logic              pWrite,
  output logic [31:0]       pAddr,
  output logic [31:0]       pWdata,
  input  logic [31:0]       pReadData
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state;
  op_e             op;
  op_e             nxt_op;
  logic            cfg_pend;
  logic [LW-1:0]   last_grant;
  logic [LW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic [7:0]      stat_q;
  logic [7:0]      nxt_byte;
  logic            tx_grant;
  logic            unused_rd;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign unused_rd = ^pReadData[31:8];

  rr_arbiter #(.NREQ(NREQ), .LW(LW)) u_arb (
    .req     (req_valid),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Op selection for the next transaction, evaluated during GAP
  always_comb begin
    nxt_op = OP_POLL;
    if (cfg_pend) begin
      case (op)
        OP_CFG_UBRR: nxt_op = OP_CFG_CR1;
        OP_CFG_CR1:  nxt_op = OP_CFG_CR0;
        default:     nxt_op = OP_CFG_UBRR;
      endcase
    end else if (op != OP_POLL) begin
      nxt_op = OP_POLL;
    end else if (stat_q[RXC]) begin
      nxt_op = OP_RXRD;
    end else if (stat_q[UDRE] && (|req_valid)) begin
      nxt_op = OP_TXWR;
    end
  end

  assign tx_grant  = (state == ST_GAP) && (nxt_op == OP_TXWR);
  assign req_ready = tx_grant ? gnt : '0;

  always_comb begin
    nxt_byte = 8'h00;
    case (nxt_op)
      OP_CFG_UBRR: nxt_byte = CFG_UBRR;
      OP_CFG_CR1:  nxt_byte = CFG_CR1;
      OP_CFG_CR0:  nxt_byte = CFG_CR0;
      OP_TXWR:     nxt_byte = req_data[{gnt_idx, 3'b000} +: 8];
      default:     nxt_byte = 8'h00;
    endcase
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state      <= ST_GAP;
      op         <= OP_POLL;
      cfg_pend   <= 1'b1;
      cfg_done   <= 1'b0;
      last_grant <= LW'(NREQ - 1);
      stat_q     <= 8'h00;
      fe_count   <= 8'h00;
      overrun    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      pSel       <= 1'b0;
      pEnable    <= 1'b0;
      pWrite     <= 1'b0;
      pAddr      <= '0;
      pWdata     <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        // GAP -> SETUP: launch the chosen op with stable address/data
        ST_GAP: begin
          op      <= nxt_op;
          state   <= ST_SETUP;
          pSel    <= 1'b1;
          pEnable <= 1'b0;
          pWrite  <= op_is_write(nxt_op);
          pAddr   <= {24'd0, op_reg(nxt_op)};
          pWdata  <= {24'd0, nxt_byte};
          if (tx_grant) last_grant <= gnt_idx;
        end
        // SETUP -> ACCESS
        ST_SETUP: begin
          pEnable <= 1'b1;
          state   <= ST_ACCESS;
        end
        // ACCESS -> GAP: capture read data, drop all strobes
        ST_ACCESS: begin
          pSel    <= 1'b0;
          pEnable <= 1'b0;
          pWrite  <= 1'b0;
          pAddr   <= '0;
          pWdata  <= '0;
          state   <= ST_GAP;
          case (op)
            OP_POLL: begin
              stat_q <= pReadData[7:0];
              if (pReadData[FE])  fe_count <= sat_inc8(fe_count);
              if (pReadData[DOR]) overrun  <= 1'b1;
            end
            OP_RXRD: begin
              rx_data  <= pReadData[7:0];
              rx_valid <= 1'b1;
            end
            OP_CFG_CR0: begin
              cfg_pend <= 1'b0;
              cfg_done <= 1'b1;
            end
            default: ;
          endcase
        end
        default: state <= ST_GAP;
      endcase
      if (cfg_start && cfg_done) begin
        cfg_pend <= 1'b1;
        cfg_done <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_sched.sv
// Directed bench for uart_apb_sched with a zero-wait register slave model
// and a bus monitor logging accesses, grants and received bytes.
module tb_uart_apb_sched;

  logic        pClk;
  logic        pReset;
  logic        cfg_start;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cfg_done;
  logic [7:0]  fe_count;
  logic        overrun;
  logic        pSel, pEnable, pWrite;
  logic [31:0] pAddr, pWdata, pReadData;

  logic [7:0] status;
  logic [7:0] rxb;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int poll_cnt = 0;

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; int cyc; } bus_t;
  typedef struct { int idx; logic [7:0] data; int cyc; } gnt_t;
  typedef struct { logic [7:0] data; int cyc; } rx_t;
  bus_t bus_q[$];
  gnt_t grant_q[$];
  rx_t  rx_q[$];

  uart_apb_sched #(.NREQ(4), .CFG_UBRR(8'h67), .CFG_CR1(8'h03), .CFG_CR0(8'h03)) dut (
    .pClk(pClk), .pReset(pReset), .cfg_start(cfg_start),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .cfg_done(cfg_done),
    .fe_count(fe_count), .overrun(overrun),
    .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite),
    .pAddr(pAddr), .pWdata(pWdata), .pReadData(pReadData)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;
  always @(posedge pClk) cyc <= cyc + 1;

  assign pReadData = (pAddr == 32'h5) ? {24'd0, status} :
                     (pAddr == 32'h1) ? {24'd0, rxb} : 32'd0;

  logic        in_setup = 1'b0, prev_acc = 1'b0, s_wr;
  logic [31:0] s_addr, s_wdata;

  always @(negedge pClk) begin
    if (!pReset) begin
      in_setup = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (prev_acc) begin
        checks++;
        if (pSel !== 1'b0) begin errors++; $display("FAIL gap_after_access: pSel=%b want 0 at cyc %0d", pSel, cyc); end
      end
      if (in_setup) begin
        checks++;
        if (!(pSel === 1'b1 && pEnable === 1'b1 && pAddr === s_addr && pWdata === s_wdata && pWrite === s_wr)) begin
          errors++;
          $display("FAIL setup_access_stable: addr=%h wdata=%h en=%b want addr=%h wdata=%h en=1", pAddr, pWdata, pEnable, s_addr, s_wdata);
        end
      end
      in_setup = pSel && !pEnable;
      s_addr = pAddr; s_wdata = pWdata; s_wr = pWrite;
      prev_acc = pSel && pEnable;
      if (pSel && pEnable) begin
        bus_q.push_back('{pAddr, pWrite, pWdata, cyc});
        if (pAddr == 32'h5 && !pWrite) poll_cnt++;
      end
      if (req_ready != 4'b0000) begin
        int gi;
        gi = -1;
        checks++;
        if (!$onehot(req_ready)) begin errors++; $display("FAIL ready_onehot: req_ready=%b", req_ready); end
        for (int i = 0; i < 4; i++) if (req_ready[i]) gi = i;
        grant_q.push_back('{gi, req_data[gi*8 +: 8], cyc});
      end
      if (rx_valid) rx_q.push_back('{rx_data, cyc});
    end
  end

  task automatic check_all_zero(input string tag);
    checks++;
    if (pSel !== 0 || pEnable !== 0 || pWrite !== 0 || pAddr !== 0 || pWdata !== 0 || req_ready !== 0 ||
        rx_valid !== 0 || rx_data !== 0 || cfg_done !== 0 || fe_count !== 0 || overrun !== 0) begin
      errors++;
      $display("FAIL %s: sel=%b en=%b wr=%b addr=%h wd=%h rdy=%b rxv=%b rxd=%h done=%b fe=%0d ovr=%b want all 0",
               tag, pSel, pEnable, pWrite, pAddr, pWdata, req_ready, rx_valid, rx_data, cfg_done, fe_count, overrun);
    end
  endtask

  task automatic test_reset();
    pReset = 1'b0; cfg_start = 1'b0; req_valid = '0; req_data = '0; status = 8'h00; rxb = 8'h00;
    repeat (3) @(negedge pClk);
    #1;
    check_all_zero("reset_outputs");
  endtask

  task automatic test_config();
    bus_q.delete();
    @(negedge pClk);
    pReset = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge pClk); #1;
      if (k == 1) begin
        checks++;
        if (pSel !== 1 || pEnable !== 0 || pAddr !== 32'h2 || pWdata !== 32'h67)
          begin errors++; $display("FAIL first_setup: sel=%b en=%b addr=%h wd=%h want 1 0 2 67", pSel, pEnable, pAddr, pWdata); end
      end
      if (k == 8) begin
        checks++;
        if (cfg_done !== 0) begin errors++; $display("FAIL cfg_done_early: got %b want 0", cfg_done); end
      end
    end
    checks++;
    if (cfg_done !== 1) begin errors++; $display("FAIL cfg_done_cycle9: got %b want 1", cfg_done); end
    for (int i = 0; i < 40 && bus_q.size() < 6; i++) @(negedge pClk);
    #1;
    checks++;
    if (bus_q.size() < 6) begin errors++; $display("FAIL cfg_txn_count: got %0d want 6", bus_q.size()); end
    else begin
      checks++;
      if (bus_q[0].addr !== 2 || bus_q[0].wr !== 1 || bus_q[0].wdata !== 32'h67 ||
          bus_q[1].addr !== 4 || bus_q[1].wr !== 1 || bus_q[1].wdata !== 32'h03 ||
          bus_q[2].addr !== 3 || bus_q[2].wr !== 1 || bus_q[2].wdata !== 32'h03)
        begin errors++; $display("FAIL cfg_sequence: %h/%h %h/%h %h/%h want 2/67 4/03 3/03",
          bus_q[0].addr, bus_q[0].wdata, bus_q[1].addr, bus_q[1].wdata, bus_q[2].addr, bus_q[2].wdata); end
      for (int j = 3; j < 6; j++) begin
        checks++;
        if (bus_q[j].addr !== 5 || bus_q[j].wr !== 0 || bus_q[j].cyc - bus_q[j-1].cyc != 3)
          begin errors++; $display("FAIL poll_pitch[%0d]: addr=%h wr=%b dcyc=%0d want 5 0 3", j, bus_q[j].addr, bus_q[j].wr, bus_q[j].cyc - bus_q[j-1].cyc); end
      end
    end
  endtask

  task automatic test_tx_round_robin();
    int widx[$];
    bus_q.delete(); grant_q.delete();
    @(negedge pClk); #1;
    status = 8'h04; req_data = 32'hA3A2A1A0; req_valid = 4'b1111;
    for (int i = 0; i < 200 && grant_q.size() < 5; i++) begin @(negedge pClk); #1; end
    @(posedge pClk); #1;
    req_valid = 4'b0000;
    repeat (10) @(negedge pClk);
    #1;
    checks++;
    if (grant_q.size() != 5) begin errors++; $display("FAIL tx_grant_count: got %0d want 5", grant_q.size()); end
    for (int i = 0; i < grant_q.size() && i < 5; i++) begin
      checks++;
      if (grant_q[i].idx != i % 4 || grant_q[i].data !== 8'(8'hA0 + i % 4))
        begin errors++; $display("FAIL tx_grant[%0d]: idx=%0d data=%h want idx=%0d data=%h", i, grant_q[i].idx, grant_q[i].data, i % 4, 8'(8'hA0 + i % 4)); end
      if (i > 0) begin
        checks++;
        if (grant_q[i].cyc - grant_q[i-1].cyc != 6)
          begin errors++; $display("FAIL tx_grant_pitch[%0d]: got %0d want 6", i, grant_q[i].cyc - grant_q[i-1].cyc); end
      end
    end
    foreach (bus_q[j]) if (bus_q[j].wr) widx.push_back(j);
    checks++;
    if (widx.size() != 5) begin errors++; $display("FAIL tx_write_count: got %0d want 5", widx.size()); end
    for (int i = 0; i < widx.size() && i < 5; i++) begin
      checks++;
      if (bus_q[widx[i]].addr !== 0 || bus_q[widx[i]].wdata !== 32'(8'hA0 + i % 4))
        begin errors++; $display("FAIL tx_write[%0d]: addr=%h wd=%h want 0 %h", i, bus_q[widx[i]].addr, bus_q[widx[i]].wdata, 8'(8'hA0 + i % 4)); end
      checks++;
      if (widx[i] == 0 || bus_q[widx[i]-1].addr !== 5 || bus_q[widx[i]-1].wr !== 0)
        begin errors++; $display("FAIL tx_poll_before[%0d]: no POLL precedes write", i); end
    end
    if (widx.size() > 0 && grant_q.size() > 0) begin
      checks++;
      if (bus_q[widx[0]].cyc != grant_q[0].cyc + 2)
        begin errors++; $display("FAIL tx_latency: access cyc %0d want %0d", bus_q[widx[0]].cyc, grant_q[0].cyc + 2); end
    end
  endtask

  task automatic test_rx_priority();
    int rd_i, wr_i;
    bus_q.delete(); grant_q.delete(); rx_q.delete();
    @(negedge pClk); #1;
    status = 8'h05; rxb = 8'h5A; req_data = 32'h0000_3C00; req_valid = 4'b0010;
    for (int i = 0; i < 80 && grant_q.size() < 1; i++) begin
      @(negedge pClk); #1;
      if (rx_q.size() > 0) status = 8'h04;
    end
    @(posedge pClk); #1;
    req_valid = 4'b0000;
    repeat (10) @(negedge pClk);
    #1;
    rd_i = -1; wr_i = -1;
    foreach (bus_q[j]) begin
      if (rd_i < 0 && bus_q[j].addr == 1 && !bus_q[j].wr) rd_i = j;
      if (wr_i < 0 && bus_q[j].addr == 0 && bus_q[j].wr) wr_i = j;
    end
    checks++;
    if (rd_i < 0 || wr_i < 0 || rd_i > wr_i) begin errors++; $display("FAIL rx_before_tx: rxrd at %0d txwr at %0d", rd_i, wr_i); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0].data !== 8'h5A)
      begin errors++; $display("FAIL rx_data: count=%0d data=%h want 1 5A", rx_q.size(), rx_q.size() ? rx_q[0].data : 8'h00); end
    else if (rd_i >= 0) begin
      checks++;
      if (rx_q[0].cyc != bus_q[rd_i].cyc + 1) begin errors++; $display("FAIL rx_timing: cyc %0d want %0d", rx_q[0].cyc, bus_q[rd_i].cyc + 1); end
    end
    checks++;
    if (grant_q.size() != 1 || grant_q[0].idx != 1 || grant_q[0].data !== 8'h3C)
      begin errors++; $display("FAIL rx_tx_grant: count=%0d want 1 grant idx 1 data 3C", grant_q.size()); end
  endtask

  task automatic test_fe_overrun();
    int base;
    bus_q.delete();
    status = 8'h08;
    base = poll_cnt;
    for (int i = 0; i < 600 && poll_cnt - base < 100; i++) begin @(negedge pClk); #1; end
    @(negedge pClk); #1;
    checks++;
    if (fe_count !== 8'd100) begin errors++; $display("FAIL fe_count_100: got %0d want 100", fe_count); end
    for (int i = 0; i < 1200 && poll_cnt - base < 300; i++) begin @(negedge pClk); #1; end
    @(negedge pClk); #1;
    checks++;
    if (fe_count !== 8'd255) begin errors++; $display("FAIL fe_count_sat: got %0d want 255", fe_count); end
    status = 8'h10;
    base = poll_cnt;
    for (int i = 0; i < 20 && poll_cnt == base; i++) begin @(negedge pClk); #1; end
    @(posedge pClk); #1;
    status = 8'h00;
    checks++;
    if (overrun !== 1 || fe_count !== 8'd255) begin errors++; $display("FAIL overrun_set: ovr=%b fe=%0d want 1 255", overrun, fe_count); end
    repeat (6) @(negedge pClk);
    #1;
    checks++;
    if (overrun !== 1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    cfg_start = 1'b1;
    @(posedge pClk); #1;
    cfg_start = 1'b0;
    checks++;
    if (overrun !== 0 || cfg_done !== 0) begin errors++; $display("FAIL cfg_start_clear: ovr=%b done=%b want 0 0", overrun, cfg_done); end
    bus_q.delete();
    for (int i = 0; i < 40 && cfg_done !== 1; i++) begin @(negedge pClk); #1; end
    begin
      bus_t w[$];
      foreach (bus_q[j]) if (bus_q[j].wr) w.push_back(bus_q[j]);
      checks++;
      if (cfg_done !== 1 || w.size() != 3 || w[0].addr !== 2 || w[1].addr !== 4 || w[2].addr !== 3 || w[0].wdata !== 32'h67)
        begin errors++; $display("FAIL cfg_rerun: done=%b writes=%0d want done=1 and writes 2,4,3", cfg_done, w.size()); end
    end
  endtask

  task automatic test_reset_mid_tx();
    logic hit, updated;
    hit = 1'b0; updated = 1'b0;
    grant_q.delete(); bus_q.delete();
    status = 8'h04; req_data = 32'h0077_0000; req_valid = 4'b0100;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge pClk); #1;
      if (grant_q.size() == 1 && !updated) begin
        @(posedge pClk); #1;
        req_data = 32'h0078_0000;
        updated = 1'b1;
      end else if (pSel && pEnable && pAddr == 32'h0) hit = 1'b1;
    end
    checks++;
    if (!hit || grant_q.size() != 1 || grant_q[0].idx != 2 || grant_q[0].data !== 8'h77 || pWdata !== 32'h77)
      begin errors++; $display("FAIL pre_reset_txwr: hit=%b grants=%0d wd=%h want 1 1 77", hit, grant_q.size(), pWdata); end
    pReset = 1'b0;
    #1;
    check_all_zero("reset_mid_txwr");
    repeat (2) @(negedge pClk);
    grant_q.delete(); bus_q.delete();
    pReset = 1'b1;
    @(posedge pClk); #1;
    checks++;
    if (pSel !== 1 || pEnable !== 0 || pAddr !== 32'h2)
      begin errors++; $display("FAIL restart_ubrr: sel=%b en=%b addr=%h want 1 0 2", pSel, pEnable, pAddr); end
    for (int i = 0; i < 80 && grant_q.size() < 1; i++) begin @(negedge pClk); #1; end
    @(posedge pClk); #1;
    req_valid = 4'b0000;
    repeat (12) @(negedge pClk);
    #1;
    checks++;
    if (grant_q.size() != 1 || grant_q[0].idx != 2 || grant_q[0].data !== 8'h78)
      begin errors++; $display("FAIL post_reset_grant: count=%0d want exactly 1 grant of 78 to client 2", grant_q.size()); end
    begin
      int nw; logic [31:0] wd;
      nw = 0; wd = '0;
      foreach (bus_q[j]) if (bus_q[j].wr && bus_q[j].addr == 0) begin nw++; wd = bus_q[j].wdata; end
      checks++;
      if (nw != 1 || wd !== 32'h78) begin errors++; $display("FAIL post_reset_txwr: writes=%0d wd=%h want 1 78", nw, wd); end
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_tx_round_robin();
    test_rx_priority();
    test_fe_overrun();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_apb_sched.md
# uart_apb_sched

APB master that configures and services the UART register block on behalf of up to `NREQ` byte-stream clients. After reset it programs UBRR/CR1/CR0, then polls StatusReg. It drains received bytes and round-robin schedules client bytes into the Tx buffer. It sits between client logic and the UART register slave on a private APB segment (zero-wait slave, no pReady).

## Interface
- `NREQ`, 4, number of Tx requesters (2..8)
- `CFG_UBRR`, 8'h67, value written to UBRR (0x02)
- `CFG_CR1`, 8'h03, value written to CR1 (0x04): DLS/STOP/PEN/EPS
- `CFG_CR0`, 8'h03, value written to CR0 (0x03): TxEn/RxEn/CIE/UBRRH
- `pClk`  in  1  clock
- `pReset`  in  1  asynchronous, active-low reset
- `cfg_start`  in  1  pulse: rerun configuration sequence
- `req_valid`  in  NREQ  client i has a byte
- `req_data`  in  8*NREQ  client i byte at [8i+7:8i]
- `req_ready`  out  NREQ  one-hot 1-cycle pulse: byte of client i accepted
- `rx_valid`  out  1  1-cycle pulse: `rx_data` valid
- `rx_data`  out  8  received byte
- `cfg_done`  out  1  configuration complete
- `fe_count`  out  8  saturating framing-error count
- `overrun`  out  1  sticky DOR seen
- `pSel`, `pEnable`, `pWrite`  out  1  APB control
- `pAddr`  out  32  APB address ({24'd0, reg index})
- `pWdata`  out  32  APB write data ({24'd0, byte})
- `pReadData`  in  32  APB read data, sampled in ACCESS

## Operation
- FSM states: SETUP, ACCESS, GAP. Op register holds the current op: CFG_UBRR, CFG_CR1, CFG_CR0, POLL (read 0x05), RXRD (read 0x01), TXWR (write 0x00).
- Every transaction is SETUP (pSel=1, pEnable=0), then ACCESS (pSel=1, pEnable=1), then GAP (all APB outputs 0). The GAP is mandatory because the slave edge-detects its strobes.
- `pAddr`, `pWrite` and `pWdata` are stable across SETUP and ACCESS. They are 0 in GAP.
- In GAP, the next op is chosen with this priority:
  - `cfg_pend` → CFG sequence.
  - Else, if the last op was not POLL → POLL.
  - Else, if `stat_q[0]` (RxC) → RXRD.
  - Else, if `stat_q[2]` (UDRE) and any `req_valid` → TXWR.
  - Else → POLL.
- CFG order is fixed: UBRR, CR1, CR0 (enables last). Each is a full 3-cycle transaction.
- `cfg_done` rises in the GAP after the CR0 ACCESS.
- `cfg_pend` resets to 1. `cfg_start` sets it only when `cfg_done`=1, and is ignored during CFG. Setting it clears `cfg_done` and `overrun`.
- POLL: ACCESS captures `pReadData[7:0]` into `stat_q`.
  - `stat_q[3]` (FE) increments `fe_count`, saturating at 255.
  - `stat_q[4]` (DOR) sets `overrun`.
- RXRD: ACCESS captures `rx_data`. `rx_valid` pulses in the following GAP cycle.
- TXWR grant is round-robin: search starts at `last_grant+1`, modulo NREQ, lowest index first on wrap.
  - In the deciding GAP, `req_ready[g]` pulses, `req_data[g]` is latched into `tx_q`, and `last_grant`=g.
  - The write data is `{24'd0, tx_q}`.
- Clients hold `req_valid`/`req_data` until `req_ready`. Dropping `req_valid` before the grant is legal; the client is skipped.
- Reset (asynchronous, any state):
  - State=GAP, `cfg_pend`=1, `last_grant`=NREQ-1, `stat_q`=0.
  - All outputs 0: APB, `req_ready`, `rx_valid`, `rx_data`, `cfg_done`, `fe_count`, `overrun`.
  - A transaction in flight is abandoned. After release, CFG restarts from UBRR.

## Timing
- First SETUP occurs 1 cycle after reset release (GAP → SETUP UBRR).
- CFG takes 9 cycles. `cfg_done`=1 in cycle 9 after the first SETUP.
- Transaction pitch is 3 cycles. Minimum Tx byte latency from `req_valid` with UDRE already set is: remaining current txn + POLL (3) + TXWR (3).
- `rx_valid` occurs 2 cycles after RXRD SETUP. `req_ready` occurs 1 cycle before TXWR SETUP.
- At most one `req_ready` or `rx_valid` per 6 cycles.
- A simultaneous RxC and UDRE serves Rx first. Tx waits at least one more POLL.

## Structure
- Package `uart_apb_pkg` holds:
  - Register index constants: TXB=0x00, RXB=0x01, UBRR=0x02, CR0=0x03, CR1=0x04, STAT=0x05.
  - Status bit positions: RXC=0, TXC=1, UDRE=2, FE=3, DOR=4.
  - Op enum and FSM state enum.
- Sub-module `rr_arbiter` (NREQ, `req` in, `last` in, one-hot `gnt` out, combinational) is natural.

## Test plan
- Reset release, slave returning 0 → writes 0x02=8'h67, 0x04=8'h03, 0x03=8'h03 in order. `cfg_done`=1 at cycle 9. POLLs to 0x05 every 3 cycles thereafter.
- Status=8'h04, `req_valid`=4'b1111, data 0xA0..0xA3 → successive TXWR bytes 0xA0, 0xA1, 0xA2, 0xA3, 0xA0, each preceded by a POLL. `req_ready` is one-hot in that order.
- Status=8'h05, RXB read returns 8'h5A → RXRD before TXWR. `rx_valid` pulses with `rx_data`=8'h5A.
- Status=8'h08 for 300 polls → `fe_count`=255 (saturated). Status=8'h10 once → `overrun`=1, cleared by `cfg_start`, which also reruns CFG.
- `pReset` low during a TXWR ACCESS → all outputs 0 immediately. After release, the first SETUP targets 0x02 and no `req_ready` is lost or duplicated.
- Every transaction shows pSel low for at least 1 cycle between ACCESS and the next SETUP; pAddr/pWdata are stable across SETUP→ACCESS.
